fetch_pipe: RTL and testbench

FETCH_PIPE -- requirements
Module: fetch_pipe

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_fifo.sv | 73 +++++++
 rtl/fetch_pipe.sv | 139 +++++++++++++
 tb/tb_fetch_pipe.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction fetch pipeline.
//   fetch_state_e   : fetch FSM state encoding (RUN, DRAIN, HALTED)
//   HALT_OP_DEFAULT : default halt pattern compared against instr[11:0]
//   PC_INC          : byte increment applied to the PC per issued request
package fetch_pkg;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_HALTED = 2'd2
   } fetch_state_e;

   localparam logic [11:0] HALT_OP_DEFAULT = 12'h300;
   localparam int unsigned PC_INC          = 4;

endpackage : fetch_pkg

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO holding fetched {instr, pc, pc+4} entries.
//   clk    in  : clock, all state on rising edge
//   reset  in  : synchronous active-high reset, empties the FIFO
//   flush  in  : synchronous flush, empties the FIFO (same effect as reset)
//   push   in  : write wdata (ignored when full)
//   pop    in  : drop head entry (ignored when empty)
//   wdata  in  : entry to write
//   rdata  out : head entry (meaningful only when empty=0)
//   count  out : number of stored entries, 0..DEPTH
//   empty  out : count == 0
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int WIDTH = 96,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = AW + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic [CW-1:0]    count,
   output logic             empty
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic [CW-1:0]    count_d;
   logic             full;
   logic             do_push;
   logic             do_pop;

   always_comb begin
      full    = (count_q == CW'(DEPTH));
      empty   = (count_q == '0);
      do_push = push && !full;
      do_pop  = pop && !empty;
      count_d = count_q;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_d;
      end
   end

   // Storage needs no reset: entries are only observed through count/empty.
   always_ff @(posedge clk) begin
      if (do_push && !reset && !flush) mem_q[wr_ptr_q] <= wdata;
   end

   assign rdata = mem_q[rd_ptr_q];
   assign count = count_q;

endmodule : fetch_fifo

// File: rtl/fetch_pipe.sv
// fetch_pipe: instruction fetch stage with a small instruction queue.
//   clk            in  : clock
//   reset          in  : synchronous active-high reset, loads PC from start_addr
//   start_addr     in  : PC loaded while reset is high
//   redirect_valid in  : branch/jump redirect strobe (ignored once halted)
//   redirect_addr  in  : redirect target
//   imem_req       out : fetch request for imem_addr
//   imem_addr      out : current PC
//   imem_rdata     in  : instruction word, valid one cycle after imem_req
//   out_valid/out_ready, out_instr, out_pc, out_pc_plus4 : decode-side stream
//   halted         out : halt word delivered and queue drained
//   dbg_state      out : current FSM state
//
// Handshake: an entry transfers on a rising edge where out_valid=1 and
// out_ready=1; out_* hold stable while out_valid=1 and out_ready=0.
module fetch_pipe
   import fetch_pkg::*;
#(
   parameter int          ADDR_W  = 32,
   parameter int          INST_W  = 32,
   parameter int          DEPTH   = 4,
   parameter logic [11:0] HALT_OP = HALT_OP_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_addr,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [INST_W-1:0] imem_rdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [INST_W-1:0] out_instr,
   output logic [ADDR_W-1:0] out_pc,
   output logic [ADDR_W-1:0] out_pc_plus4,
   output logic              halted,
   output fetch_state_e      dbg_state
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int EW = INST_W + 2 * ADDR_W;

   fetch_state_e      state_q;
   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] inflight_pc_q;
   logic              inflight_q;

   logic [CW-1:0]     count;
   logic              fifo_empty;
   logic [EW-1:0]     fifo_rdata;
   logic [EW-1:0]     fifo_wdata;
   logic              push;
   logic              pop;
   logic              flush;
   logic              halt_hit;
   logic              issue;
   int                occupancy;

   always_comb begin
      out_valid = !reset && !fifo_empty && (state_q != ST_HALTED);
      pop       = out_valid && out_ready;
      // The response is only captured while running; a redirect kills it,
      // and in DRAIN any straggler is dropped.
      push      = !reset && inflight_q && (state_q == ST_RUN) && !redirect_valid;
      halt_hit  = push && (imem_rdata[11:0] == HALT_OP);
      flush     = redirect_valid && (state_q != ST_HALTED);
      // Slots already promised: stored entries plus the response in flight,
      // minus the one leaving this cycle.
      occupancy = int'(count) + (inflight_q ? 1 : 0) - (pop ? 1 : 0);
      // Requests stop as soon as the halt word is seen, so nothing past it
      // is ever fetched.
      issue     = !reset && (state_q == ST_RUN) && !redirect_valid && !halt_hit
                  && (occupancy < DEPTH);
      fifo_wdata = {imem_rdata, inflight_pc_q, inflight_pc_q + ADDR_W'(PC_INC)};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_RUN;
         pc_q          <= start_addr;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
      end else begin
         case (state_q)
            ST_RUN, ST_DRAIN: begin
               if (redirect_valid) begin
                  state_q    <= ST_RUN;
                  pc_q       <= redirect_addr;
                  inflight_q <= 1'b0;
               end else begin
                  inflight_q <= issue;
                  if (issue) begin
                     inflight_pc_q <= pc_q;
                     pc_q          <= pc_q + ADDR_W'(PC_INC);
                  end
                  if (halt_hit) begin
                     state_q <= ST_DRAIN;
                  end else if ((state_q == ST_DRAIN) &&
                               ((count == '0) || ((count == CW'(1)) && pop))) begin
                     state_q <= ST_HALTED;
                  end
               end
            end
            ST_HALTED: begin
               inflight_q <= 1'b0;
            end
            default: begin
               state_q    <= ST_RUN;
               inflight_q <= 1'b0;
            end
         endcase
      end
   end

   fetch_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .push  (push),
      .pop   (pop),
      .wdata (fifo_wdata),
      .rdata (fifo_rdata),
      .count (count),
      .empty (fifo_empty)
   );

   assign imem_req     = issue;
   assign imem_addr    = pc_q;
   assign out_instr    = reset ? '0 : fifo_rdata[EW-1 -: INST_W];
   assign out_pc       = reset ? '0 : fifo_rdata[2*ADDR_W-1 -: ADDR_W];
   assign out_pc_plus4 = reset ? '0 : fifo_rdata[ADDR_W-1:0];
   assign halted       = !reset && (state_q == ST_HALTED);
   assign dbg_state    = state_q;

endmodule : fetch_pipe

// File: tb/tb_fetch_pipe.sv
module tb_fetch_pipe;
   import fetch_pkg::*;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [31:0]  start_addr = 32'h100;
   logic         redirect_valid = 1'b0;
   logic [31:0]  redirect_addr = '0;
   logic         imem_req;
   logic [31:0]  imem_addr;
   logic [31:0]  imem_rdata = '0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [31:0]  out_instr;
   logic [31:0]  out_pc;
   logic [31:0]  out_pc_plus4;
   logic         halted;
   fetch_state_e dbg_state;

   int           checks = 0;
   int           errors = 0;
   int           req_count = 0;
   logic [31:0]  halt_addr = 32'h1;

   fetch_pipe dut (
      .clk            (clk),
      .reset          (reset),
      .start_addr     (start_addr),
      .redirect_valid (redirect_valid),
      .redirect_addr  (redirect_addr),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc),
      .out_pc_plus4   (out_pc_plus4),
      .halted         (halted),
      .dbg_state      (dbg_state)
   );

   always #5 clk = ~clk;

   // Address-derived words; low 12 bits are never 0x300 except at halt_addr.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == halt_addr) return 32'h0000_0300;
      return {a[23:0], 8'hA5};
   endfunction

   // Memory: answers one cycle after each request; drives a halt-looking
   // pattern when no answer is due so a stray capture would show up.
   always @(posedge clk) begin
      if (imem_req) begin
         imem_rdata <= mem_word(imem_addr);
         req_count  <= req_count + 1;
      end else begin
         imem_rdata <= 32'hBAD0_0300;
      end
   end

   // Holds reset for two edges, releases it at a falling edge; caller samples #1 later.
   task automatic apply_reset(input logic [31:0] s);
      @(negedge clk);
      reset = 1'b1;
      start_addr = s;
      redirect_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset = 1'b1;
      start_addr = 32'h100;
      redirect_valid = 1'b0;
      out_ready = 1'b1;
      #1;
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %0h exp 0", imem_req); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0h exp 0", out_valid); end
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted: got %0h exp 0", halted); end
      checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL rst_out_pc: got %0h exp 0", out_pc); end
      checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL rst_out_instr: got %0h exp 0", out_instr); end
      checks++; if (out_pc_plus4 !== 32'h0) begin errors++; $display("FAIL rst_out_pc4: got %0h exp 0", out_pc_plus4); end
      @(posedge clk);
      @(negedge clk);
      #1;
      checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL rst_pc_load: got %0h exp 100", imem_addr); end
      checks++; if (dbg_state !== ST_RUN) begin errors++; $display("FAIL rst_state: got %0d exp %0d", dbg_state, ST_RUN); end
   endtask

   task automatic test_stream();
      out_ready = 1'b1;
      apply_reset(32'h100);
      #1;
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL st_c0_req: got %0h exp 1", imem_req); end
      checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL st_c0_addr: got %0h exp 100", imem_addr); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL st_c0_valid: got %0h exp 0", out_valid); end
      @(negedge clk); #1;
      checks++; if (imem_addr !== 32'h104) begin errors++; $display("FAIL st_c1_addr: got %0h exp 104", imem_addr); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL st_c1_valid: got %0h exp 0", out_valid); end
      @(negedge clk); #1;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL st_c2_valid: got %0h exp 1", out_valid); end
      checks++; if (out_pc !== 32'h100) begin errors++; $display("FAIL st_c2_pc: got %0h exp 100", out_pc); end
      checks++; if (out_pc_plus4 !== 32'h104) begin errors++; $display("FAIL st_c2_pc4: got %0h exp 104", out_pc_plus4); end
      checks++; if (out_instr !== 32'h0001_00A5) begin errors++; $display("FAIL st_c2_instr: got %0h exp 100a5", out_instr); end
      checks++; if (imem_addr !== 32'h108) begin errors++; $display("FAIL st_c2_addr: got %0h exp 108", imem_addr); end
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk); #1;
         checks++; if (out_valid !== 1'b1 || out_pc !== 32'h100 + 32'(4 * k)) begin
            errors++; $display("FAIL st_thru: got valid %0h pc %0h exp valid 1 pc %0h", out_valid, out_pc, 32'h100 + 32'(4 * k));
         end
      end
   endtask

   task automatic test_backpressure();
      int base;
      int got;
      logic [31:0] exp_pc;
      out_ready = 1'b0;
      apply_reset(32'h100);
      base = req_count;
      #1;
      for (int i = 0; i < 10; i++) begin
         if (i > 0) begin @(negedge clk); #1; end
         if (out_valid === 1'b1) begin
            checks++; if (out_pc !== 32'h100 || out_instr !== 32'h0001_00A5) begin
               errors++; $display("FAIL bp_hold: got pc %0h instr %0h exp pc 100 instr 100a5", out_pc, out_instr);
            end
         end
      end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL bp_req_low: got %0h exp 0", imem_req); end
      checks++; if (req_count - base !== 4) begin errors++; $display("FAIL bp_req_cnt: got %0d exp 4", req_count - base); end
      checks++; if (imem_addr !== 32'h110) begin errors++; $display("FAIL bp_addr: got %0h exp 110", imem_addr); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %0h exp 1", out_valid); end
      got = 0;
      exp_pc = 32'h100;
      for (int i = 0; i < 30 && got < 12; i++) begin
         @(negedge clk);
         out_ready = 1'b1;
         #1;
         if (out_valid === 1'b1) begin
            checks++; if (out_pc !== exp_pc) begin errors++; $display("FAIL bp_order: got %0h exp %0h", out_pc, exp_pc); end
            exp_pc += 32'h4;
            got++;
         end
      end
      checks++; if (got != 12) begin errors++; $display("FAIL bp_timeout: got %0d entries exp 12", got); end
   endtask

   task automatic test_redirect();
      out_ready = 1'b0;
      apply_reset(32'h100);
      #1;
      repeat (3) @(negedge clk);
      #1;
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10C) begin
         errors++; $display("FAIL rd_c3: got req %0h addr %0h exp req 1 addr 10c", imem_req, imem_addr);
      end
      @(negedge clk);
      redirect_valid = 1'b1;
      redirect_addr = 32'h200;
      out_ready = 1'b1;
      #1;
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rd_no_req: got %0h exp 0", imem_req); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rd_pre_valid: got %0h exp 1", out_valid); end
      @(negedge clk);
      redirect_valid = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rd_flush: got %0h exp 0", out_valid); end
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin
         errors++; $display("FAIL rd_target: got req %0h addr %0h exp req 1 addr 200", imem_req, imem_addr);
      end
      @(negedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rd_c6_valid: got %0h exp 0", out_valid); end
      @(negedge clk); #1;
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'h200) begin
         errors++; $display("FAIL rd_first: got valid %0h pc %0h exp valid 1 pc 200", out_valid, out_pc);
      end
      checks++; if (out_instr !== 32'h0002_00A5) begin errors++; $display("FAIL rd_instr: got %0h exp 200a5", out_instr); end
      for (int k = 1; k <= 2; k++) begin
         @(negedge clk); #1;
         checks++; if (out_valid !== 1'b1 || out_pc !== 32'h200 + 32'(4 * k)) begin
            errors++; $display("FAIL rd_next: got valid %0h pc %0h exp valid 1 pc %0h", out_valid, out_pc, 32'h200 + 32'(4 * k));
         end
      end
   endtask

   task automatic test_halt();
      int base;
      out_ready = 1'b1;
      halt_addr = 32'h10C;
      apply_reset(32'h100);
      base = req_count;
      #1;
      repeat (3) @(negedge clk);
      #1;
      checks++; if (imem_addr !== 32'h10C || out_pc !== 32'h104) begin
         errors++; $display("FAIL ht_c3: got addr %0h pc %0h exp addr 10c pc 104", imem_addr, out_pc);
      end
      @(negedge clk); #1;
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL ht_c4_req: got %0h exp 0", imem_req); end
      checks++; if (out_pc !== 32'h108) begin errors++; $display("FAIL ht_c4_pc: got %0h exp 108", out_pc); end
      @(negedge clk); #1;
      checks++; if (dbg_state !== ST_DRAIN) begin errors++; $display("FAIL ht_drain: got %0d exp %0d", dbg_state, ST_DRAIN); end
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'h10C || out_instr !== 32'h300) begin
         errors++; $display("FAIL ht_word: got valid %0h pc %0h instr %0h exp 1 10c 300", out_valid, out_pc, out_instr);
      end
      checks++; if (halted !== 1'b0 || imem_req !== 1'b0) begin
         errors++; $display("FAIL ht_c5: got halted %0h req %0h exp 0 0", halted, imem_req);
      end
      @(negedge clk); #1;
      checks++; if (halted !== 1'b1 || out_valid !== 1'b0 || imem_req !== 1'b0) begin
         errors++; $display("FAIL ht_halted: got halted %0h valid %0h req %0h exp 1 0 0", halted, out_valid, imem_req);
      end
      @(negedge clk);
      redirect_valid = 1'b1;
      redirect_addr = 32'h200;
      #1;
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL ht_redir_req: got %0h exp 0", imem_req); end
      @(negedge clk);
      redirect_valid = 1'b0;
      #1;
      checks++; if (halted !== 1'b1 || out_valid !== 1'b0 || imem_req !== 1'b0) begin
         errors++; $display("FAIL ht_sticky: got halted %0h valid %0h req %0h exp 1 0 0", halted, out_valid, imem_req);
      end
      checks++; if (req_count - base !== 4) begin errors++; $display("FAIL ht_req_cnt: got %0d exp 4", req_count - base); end
      halt_addr = 32'h1;
   endtask

   task automatic test_redirect_on_halt();
      out_ready = 1'b1;
      halt_addr = 32'h10C;
      apply_reset(32'h100);
      #1;
      repeat (4) @(negedge clk);
      redirect_valid = 1'b1;
      redirect_addr = 32'h400;
      #1;
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rh_req: got %0h exp 0", imem_req); end
      @(negedge clk);
      redirect_valid = 1'b0;
      #1;
      checks++; if (dbg_state !== ST_RUN) begin errors++; $display("FAIL rh_state: got %0d exp %0d", dbg_state, ST_RUN); end
      checks++; if (out_valid !== 1'b0 || halted !== 1'b0) begin
         errors++; $display("FAIL rh_flush: got valid %0h halted %0h exp 0 0", out_valid, halted);
      end
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h400) begin
         errors++; $display("FAIL rh_target: got req %0h addr %0h exp 1 400", imem_req, imem_addr);
      end
      @(negedge clk); #1;
      @(negedge clk); #1;
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'h400 || out_instr !== 32'h0004_00A5) begin
         errors++; $display("FAIL rh_first: got valid %0h pc %0h instr %0h exp 1 400 400a5", out_valid, out_pc, out_instr);
      end
      halt_addr = 32'h1;
   endtask

   task automatic test_wrap();
      out_ready = 1'b1;
      apply_reset(32'hFFFF_FFFC);
      #1;
      checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wr_c0: got %0h exp fffffffc", imem_addr); end
      @(negedge clk); #1;
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
         errors++; $display("FAIL wr_c1: got req %0h addr %0h exp 1 0", imem_req, imem_addr);
      end
      @(negedge clk); #1;
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'hFFFF_FFFC || out_pc_plus4 !== 32'h0) begin
         errors++; $display("FAIL wr_out: got valid %0h pc %0h pc4 %0h exp 1 fffffffc 0", out_valid, out_pc, out_pc_plus4);
      end
      @(negedge clk); #1;
      checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL wr_next: got %0h exp 0", out_pc); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_halt();
      test_reset();
      test_redirect_on_halt();
      test_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout exp finish");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_fetch_pipe
